// File: rtl/control_sequencer_if.sv
// Control bus between the controller-sequencer and the SAP datapath.
// Optional single-step input is present only when SINGLE_STEP_EN is defined.
interface control_sequencer_if;
  logic [3:0] IR_op;
  logic [5:0] t_state;
  logic       IPC;
  logic       EP;
  logic       LM;
  logic       CE;
  logic       LI;
  logic       EI;
  logic       LA;
  logic       EA;
  logic       SU;
  logic       EU;
  logic       LB;
  logic       LO;
  logic       halted;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  // Sequencer side: consumes the opcode, drives every strobe
  modport master (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  IR_op,
    output t_state, IPC, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, halted
  );

  // Datapath side: supplies the opcode, obeys the strobes
  modport slave (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output IR_op,
    input  t_state, IPC, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-style controller-sequencer: 6-state one-hot T-ring (T1..T3 fetch,
// T4..T6 execute) with combinational opcode decode into bus/load strobes.
// Build option SINGLE_STEP_EN: ring and halt latch advance only when step=1.
module control_sequencer (
  input  logic                 clk,
  input  logic                 CLRn,
  control_sequencer_if.master  bus
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q;
  logic    halted_q;
  logic    adv;

`ifdef SINGLE_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  // Ring counter and halt latch; HLT decoded in T4 freezes the ring there
  always_ff @(posedge clk or posedge CLRn) begin
    if (CLRn) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else if (adv && !halted_q) begin
      case (state_q)
        T1:      state_q <= T2;
        T2:      state_q <= T3;
        T3:      state_q <= T4;
        T4: begin
          if (bus.IR_op == OP_HLT) halted_q <= 1'b1;
          else                     state_q  <= T5;
        end
        T5:      state_q <= T6;
        T6:      state_q <= T1;
        default: state_q <= T1;
      endcase
    end
  end

  logic ipc_c, ep_c, lm_c, ce_c, li_c, ei_c, la_c, ea_c, su_c, eu_c, lb_c, lo_c;

  // Strobe decode from T-state and opcode, forced low in reset or halt
  always_comb begin
    ipc_c = 1'b0; ep_c = 1'b0; lm_c = 1'b0; ce_c = 1'b0;
    li_c  = 1'b0; ei_c = 1'b0; la_c = 1'b0; ea_c = 1'b0;
    su_c  = 1'b0; eu_c = 1'b0; lb_c = 1'b0; lo_c = 1'b0;
    if (!CLRn && !halted_q) begin
      case (state_q)
        T1: begin ep_c = 1'b1; lm_c = 1'b1; end
        T2: ipc_c = 1'b1;
        T3: begin ce_c = 1'b1; li_c = 1'b1; end
        T4: begin
          case (bus.IR_op)
            OP_LDA, OP_ADD, OP_SUB: begin ei_c = 1'b1; lm_c = 1'b1; end
            OP_OUT:                 begin ea_c = 1'b1; lo_c = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (bus.IR_op)
            OP_LDA:         begin ce_c = 1'b1; la_c = 1'b1; end
            OP_ADD, OP_SUB: begin ce_c = 1'b1; lb_c = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (bus.IR_op)
            OP_ADD: begin eu_c = 1'b1; la_c = 1'b1; end
            OP_SUB: begin eu_c = 1'b1; su_c = 1'b1; la_c = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state = 6'(state_q);
  assign bus.halted  = halted_q;
  assign bus.IPC     = ipc_c;
  assign bus.EP      = ep_c;
  assign bus.LM      = lm_c;
  assign bus.CE      = ce_c;
  assign bus.LI      = li_c;
  assign bus.EI      = ei_c;
  assign bus.LA      = la_c;
  assign bus.EA      = ea_c;
  assign bus.SU      = su_c;
  assign bus.EU      = eu_c;
  assign bus.LB      = lb_c;
  assign bus.LO      = lo_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the expected
// T-state/strobes/halted per cycle, a monitor pops and compares.
module tb_control_sequencer;

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100,
                         T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;

  // Strobe vector order: {IPC,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO}
  localparam logic [11:0] M_IPC = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                          M_CE  = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                          M_LA  = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                          M_EU  = 12'h004, M_LB = 12'h002, M_LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  logic clk = 1'b0;
  logic CLRn;
  logic step_v;

  control_sequencer_if bus ();

`ifdef SINGLE_STEP_EN
  assign bus.step = step_v;
`endif

  control_sequencer dut (
    .clk  (clk),
    .CLRn (CLRn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  st;
    logic [11:0] sb;
    logic        h;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compares outputs on every falling edge or on an async sample request
  initial begin
    exp_t e;
    logic [11:0] sb;
    forever begin
      @(negedge clk or sample_ev);
      if (q.size() != 0) begin
        e  = q.pop_front();
        sb = {bus.IPC, bus.EP, bus.LM, bus.CE, bus.LI, bus.EI,
              bus.LA, bus.EA, bus.SU, bus.EU, bus.LB, bus.LO};
        chk({e.nm, "/t_state"}, 32'(bus.t_state), 32'(e.st));
        chk({e.nm, "/strobes"}, 32'(sb), 32'(e.sb));
        chk({e.nm, "/halted"}, 32'(bus.halted), 32'(e.h));
        chk({e.nm, "/onehot"}, 32'($onehot(bus.t_state)), 32'd1);
        chk({e.nm, "/bus_excl"},
            32'($countones({bus.EP, bus.CE, bus.EI, bus.EA, bus.EU}) <= 1), 32'd1);
      end
    end
  end

  // One cycle: drive inputs just after the rising edge and queue the expected outputs
  task automatic cyc(input logic clrn, input logic [3:0] op, input logic stp,
                     input logic [5:0] st, input logic [11:0] sb, input logic h,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    CLRn       = clrn;
    bus.IR_op  = op;
    step_v     = stp;
    e.nm = nm; e.st = st; e.sb = sb; e.h = h;
    q.push_back(e);
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [11:0] e4,
                           input logic [11:0] e5, input logic [11:0] e6,
                           input string nm);
    cyc(1'b0, op, 1'b1, T1, M_EP | M_LM, 1'b0, {nm, "_T1"});
    cyc(1'b0, op, 1'b1, T2, M_IPC,       1'b0, {nm, "_T2"});
    cyc(1'b0, op, 1'b1, T3, M_CE | M_LI, 1'b0, {nm, "_T3"});
    cyc(1'b0, op, 1'b1, T4, e4,          1'b0, {nm, "_T4"});
    cyc(1'b0, op, 1'b1, T5, e5,          1'b0, {nm, "_T5"});
    cyc(1'b0, op, 1'b1, T6, e6,          1'b0, {nm, "_T6"});
  endtask

  // Stimulus
  initial begin
    exp_t e;
    CLRn      = 1'b1;
    bus.IR_op = 4'b0101;
    step_v    = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0101, 1'b1, T1, NONE, 1'b0, "reset");

    run_instr(4'b0101, NONE, NONE, NONE, "nop_a");
    run_instr(4'b0101, NONE, NONE, NONE, "nop_b");
    run_instr(4'b0010, M_EI | M_LM, M_CE | M_LB, M_EU | M_SU | M_LA, "sub");
    run_instr(4'b0000, M_EI | M_LM, M_CE | M_LA, NONE, "lda");
    run_instr(4'b0001, M_EI | M_LM, M_CE | M_LB, M_EU | M_LA, "add");
    run_instr(4'b1110, M_EA | M_LO, NONE, NONE, "out");

    // ADD interrupted by an asynchronous clear pulse inside T5
    cyc(1'b0, 4'b0001, 1'b1, T1, M_EP | M_LM, 1'b0, "mid_T1");
    cyc(1'b0, 4'b0001, 1'b1, T2, M_IPC,       1'b0, "mid_T2");
    cyc(1'b0, 4'b0001, 1'b1, T3, M_CE | M_LI, 1'b0, "mid_T3");
    cyc(1'b0, 4'b0001, 1'b1, T4, M_EI | M_LM, 1'b0, "mid_T4");
    cyc(1'b0, 4'b0001, 1'b1, T5, M_CE | M_LB, 1'b0, "mid_T5");
    @(negedge clk);
    #1 CLRn = 1'b1;
    #1;
    e.nm = "mid_async"; e.st = T1; e.sb = NONE; e.h = 1'b0;
    q.push_back(e);
    -> sample_ev;
    #1 CLRn = 1'b0;
    cyc(1'b0, 4'b0001, 1'b1, T2, M_IPC,             1'b0, "restart_T2");
    cyc(1'b0, 4'b0001, 1'b1, T3, M_CE | M_LI,       1'b0, "restart_T3");
    cyc(1'b0, 4'b0001, 1'b1, T4, M_EI | M_LM,       1'b0, "restart_T4");
    cyc(1'b0, 4'b0001, 1'b1, T5, M_CE | M_LB,       1'b0, "restart_T5");
    cyc(1'b0, 4'b0001, 1'b1, T6, M_EU | M_LA,       1'b0, "restart_T6");

`ifdef SINGLE_STEP_EN
    // Hold in T2 with step low: IPC stays high, ring does not move
    cyc(1'b0, 4'b0101, 1'b1, T1, M_EP | M_LM, 1'b0, "ss_T1");
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0101, 1'b0, T2, M_IPC, 1'b0, "ss_hold");
    cyc(1'b0, 4'b0101, 1'b1, T2, M_IPC,       1'b0, "ss_go");
    cyc(1'b0, 4'b0101, 1'b1, T3, M_CE | M_LI, 1'b0, "ss_T3");
    cyc(1'b0, 4'b0101, 1'b1, T4, NONE,        1'b0, "ss_T4");
    cyc(1'b0, 4'b0101, 1'b1, T5, NONE,        1'b0, "ss_T5");
    cyc(1'b0, 4'b0101, 1'b1, T6, NONE,        1'b0, "ss_T6");
`endif

    // HLT: freeze at T4, strobes gated even if the opcode changes
    cyc(1'b0, 4'b1111, 1'b1, T1, M_EP | M_LM, 1'b0, "hlt_T1");
    cyc(1'b0, 4'b1111, 1'b1, T2, M_IPC,       1'b0, "hlt_T2");
    cyc(1'b0, 4'b1111, 1'b1, T3, M_CE | M_LI, 1'b0, "hlt_T3");
    cyc(1'b0, 4'b1111, 1'b1, T4, NONE,        1'b0, "hlt_T4");
    for (int i = 0; i < 20; i++)
      cyc(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0010, 1'b1, T4, NONE, 1'b1, "halted");
    cyc(1'b1, 4'b0101, 1'b1, T1, NONE, 1'b0, "hlt_clear");
    run_instr(4'b0101, NONE, NONE, NONE, "post_hlt");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- SAP-style controller-sequencer for the 8-bit CPU; sits directly upstream of the program counter and generates its IPC increment strobe.
- A 6-state one-hot ring counter (T1..T6) drives fetch (T1–T3) and execute (T4–T6) micro-steps.
- Decodes the opcode nibble from the instruction register into bus-enable and load strobes for PC, MAR, RAM, IR, A, ALU, B and OUT.

Parameters:
- OP_LDA, 4'b0000, load A from memory
- OP_ADD, 4'b0001, A <= A + B (B loaded from memory)
- OP_SUB, 4'b0010, A <= A - B
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- clk  in  1  system clock; state updates on rising edge
- CLRn  in  1  asynchronous, active-high reset (high = clear); shared with PC
- IR_op  in  4  opcode, upper nibble of instruction register
- t_state  out  6  one-hot current T-state; bit0 = T1
- IPC  out  1  PC increment strobe
- EP  out  1  PC drives bus
- LM  out  1  MAR load
- CE  out  1  RAM drives bus
- LI  out  1  IR load
- EI  out  1  IR operand nibble drives bus
- LA  out  1  A load
- EA  out  1  A drives bus
- SU  out  1  ALU subtract select
- EU  out  1  ALU drives bus
- LB  out  1  B load
- LO  out  1  output register load
- halted  out  1  HLT executed

Behaviour:
- Reset
  - CLRn=1 forces t_state=6'b000001 and halted=0 immediately, independent of clk.
  - While CLRn=1, all control outputs (IPC..LO) are 0.
  - The first rising clk edge after CLRn falls advances T1 -> T2.
  - Reset mid-instruction abandons that instruction. No partial state survives.
- Ring counter
  - Advances one position per rising edge: T1 -> T2 -> ... -> T6 -> T1 (wrap).
  - Each instruction takes exactly 6 cycles, including NOP-class and OUT.
  - At most one t_state bit is high at any time.
- Control outputs
  - Combinational decode of the current t_state and IR_op, gated low when halted=1 or CLRn=1.
- Fetch, independent of IR_op:
  - T1: EP, LM
  - T2: IPC (PC advances once per instruction)
  - T3: CE, LI
- Execute, IR_op is valid from T4 and must stay stable through T6:
  - LDA: T4 EI, LM; T5 CE, LA; T6 none
  - ADD: T4 EI, LM; T5 CE, LB; T6 EU, LA
  - SUB: T4 EI, LM; T5 CE, LB; T6 EU, SU, LA
  - OUT: T4 EA, LO; T5 none; T6 none
  - Any other opcode: NOP, no strobes in T4–T6
  - HLT: at the T4 rising edge, halted <= 1 and the ring freezes at T4 (t_state=6'b001000).
    - All strobes stay 0 until CLRn.
    - IPC never pulses again while halted.
- Bus exclusivity: at most one of EP, CE, EI, EA, EU is high in any cycle.
- Simultaneous events: CLRn asserted on the same edge as HLT decode means reset wins (halted=0, T1).

Optional Feature:
- Macro: SINGLE_STEP_EN
- Defined:
  - Adds input step (1 bit).
  - The ring and halt latch advance only on edges where step=1. When step=0 the state holds.
  - Strobes reflect the held state. IPC therefore stays high across a held T2.
  - The PC must sample IPC only on stepped cycles; the top level ANDs IPC with step.
  - Reset is unaffected by step.
- Undefined: no step port; advances every cycle as above.

Test Plan:
- Reset: CLRn=1 for 3 cycles, then 0 -> t_state=000001 during reset, all strobes 0; after release T2 follows one edge later, halted=0.
- Fetch: IR_op=4'b0101 (NOP), run 12 cycles -> IPC high exactly in cycles 2 and 8; EP/LM in cycles 1 and 7; CE/LI in cycles 3 and 9; no strobes in T4–T6.
- SUB: IR_op=4'b0010 -> T4 {EI,LM}, T5 {CE,LB}, T6 {EU,SU,LA}; SU low in every other cycle; one-hot and bus-exclusivity checks hold every cycle.
- HLT: IR_op=4'b1111 -> halted=1 after the T4 edge; t_state stays 001000 for 20 cycles; IPC=0 throughout; CLRn pulse returns to T1 with halted=0.
- Mid-instruction reset: assert CLRn asynchronously during T5 of ADD -> t_state=000001 before the next edge, LB/CE drop at once, sequence restarts at T1.
- SINGLE_STEP_EN build: step=0 for 5 cycles in T2 -> t_state stays 000010, IPC held high; step=1 for one cycle -> T3.
